// File: rtl/button_debouncer_if.sv
// Button debouncer bus interface.
//
// Groups the button-side signals of button_debouncer so that the block and
// its consumers share one bundle.
//   button_n       : raw active-low buttons (driven by master)
//   reset_s2_n     : synchronized reset (driven by slave)
//   button_pressed : one-cycle press / repeat pulses (driven by slave)
//   button_held    : debounced pressed level (driven by slave)
// Modports: master = button source / result consumer, slave = debouncer.
interface button_debouncer_if #(
    parameter int unsigned BUTTON_COUNT = 3
);
    logic [BUTTON_COUNT-1:0] button_n;
    logic                    reset_s2_n;
    logic [BUTTON_COUNT-1:0] button_pressed;
    logic [BUTTON_COUNT-1:0] button_held;

    modport master (
        output button_n,
        input  reset_s2_n,
        input  button_pressed,
        input  button_held
    );

    modport slave (
        input  button_n,
        output reset_s2_n,
        output button_pressed,
        output button_held
    );
endinterface

// File: rtl/button_debouncer.sv
// Button debouncer.
//
// Synchronizes the asynchronous reset and the active-low raw buttons, then
// runs one counter-based debounce FSM per button. Emits a one-cycle pulse per
// accepted press and a debounced held level.
//
// Optional feature macro: BUTTON_DEBOUNCER_REPEAT_EN
//   defined   : a held button produces auto-repeat pulses, the first one
//               REPEAT_DELAY_CYCLES after the press pulse, then one every
//               REPEAT_PERIOD_CYCLES.
//   undefined : exactly one pulse per press.
//
// Ports:
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   bus     : button_debouncer_if.slave (button_n in; reset_s2_n,
//             button_pressed, button_held out)
module button_debouncer #(
    parameter int unsigned BUTTON_COUNT         = 3,
    parameter int unsigned DEBOUNCE_CYCLES      = 1_000_000,
    parameter int unsigned REPEAT_DELAY_CYCLES  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD_CYCLES = 5_000_000
) (
    input  logic              clock,
    input  logic              reset_n,
    button_debouncer_if.slave bus
);

    localparam int unsigned MAX_DR = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES)
                                     ? DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_DR > REPEAT_PERIOD_CYCLES)
                                         ? MAX_DR : REPEAT_PERIOD_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES) + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DEB_LAST = cnt_t'(DEBOUNCE_CYCLES - 1);
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
    localparam cnt_t DLY_LAST = cnt_t'(REPEAT_DELAY_CYCLES - 1);
    localparam cnt_t PER_LAST = cnt_t'(REPEAT_PERIOD_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        S_RELEASED,
        S_PRESS_PENDING,
        S_PRESSED,
        S_RELEASE_PENDING
    } state_t;

    // Reset synchronizer: asserts immediately, releases after two edges.
    logic r_rst_s1;
    logic r_rst_s2;
    logic w_rst_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_s1 <= 1'b0;
            r_rst_s2 <= 1'b0;
        end else begin
            r_rst_s1 <= 1'b1;
            r_rst_s2 <= r_rst_s1;
        end
    end

    assign w_rst_n        = r_rst_s2;
    assign bus.reset_s2_n = r_rst_s2;

    // Button synchronizer, reset to released (1).
    logic [BUTTON_COUNT-1:0] r_btn_s1;
    logic [BUTTON_COUNT-1:0] r_btn_s2;

    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_btn_s1 <= '1;
            r_btn_s2 <= '1;
        end else begin
            r_btn_s1 <= bus.button_n;
            r_btn_s2 <= r_btn_s1;
        end
    end

    // Per-button debounce FSMs.
    state_t                  r_state      [BUTTON_COUNT];
    state_t                  w_state_nxt  [BUTTON_COUNT];
    cnt_t                    r_cnt        [BUTTON_COUNT];
    cnt_t                    w_cnt_nxt    [BUTTON_COUNT];
    // 0: waiting out the initial repeat delay, 1: in periodic repeat.
    logic [BUTTON_COUNT-1:0] r_rep_phase;
    logic [BUTTON_COUNT-1:0] w_rep_phase_nxt;
    logic [BUTTON_COUNT-1:0] w_pulse_nxt;
    logic [BUTTON_COUNT-1:0] w_held_nxt;
    logic [BUTTON_COUNT-1:0] r_pressed;
    logic [BUTTON_COUNT-1:0] r_held;

    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int unsigned i = 0; i < BUTTON_COUNT; i++) begin
                r_state[i] <= S_RELEASED;
                r_cnt[i]   <= '0;
            end
            r_rep_phase <= '0;
            r_pressed   <= '0;
            r_held      <= '0;
        end else begin
            for (int unsigned i = 0; i < BUTTON_COUNT; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            r_rep_phase <= w_rep_phase_nxt;
            r_pressed   <= w_pulse_nxt;
            r_held      <= w_held_nxt;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < BUTTON_COUNT; i++) begin
            w_state_nxt[i]     = r_state[i];
            w_cnt_nxt[i]       = r_cnt[i];
            w_rep_phase_nxt[i] = r_rep_phase[i];
            w_pulse_nxt[i]     = 1'b0;

            case (r_state[i])
                S_RELEASED: begin
                    if (!r_btn_s2[i]) begin
                        w_state_nxt[i] = S_PRESS_PENDING;
                        w_cnt_nxt[i]   = '0;
                    end
                end
                S_PRESS_PENDING: begin
                    if (r_btn_s2[i]) begin
                        w_state_nxt[i] = S_RELEASED;
                    end else if (r_cnt[i] == DEB_LAST) begin
                        w_state_nxt[i]     = S_PRESSED;
                        w_cnt_nxt[i]       = '0;
                        w_rep_phase_nxt[i] = 1'b0;
                        w_pulse_nxt[i]     = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + cnt_t'(1);
                    end
                end
                S_PRESSED: begin
                    if (r_btn_s2[i]) begin
                        w_state_nxt[i] = S_RELEASE_PENDING;
                        w_cnt_nxt[i]   = '0;
                    end else begin
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
                        if (r_cnt[i] == (r_rep_phase[i] ? PER_LAST : DLY_LAST)) begin
                            w_cnt_nxt[i]       = '0;
                            w_rep_phase_nxt[i] = 1'b1;
                            w_pulse_nxt[i]     = 1'b1;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] + cnt_t'(1);
                        end
`endif
                    end
                end
                S_RELEASE_PENDING: begin
                    // A release glitch restores PRESSED silently and restarts
                    // the repeat timing from the initial delay.
                    if (!r_btn_s2[i]) begin
                        w_state_nxt[i]     = S_PRESSED;
                        w_cnt_nxt[i]       = '0;
                        w_rep_phase_nxt[i] = 1'b0;
                    end else if (r_cnt[i] == DEB_LAST) begin
                        w_state_nxt[i] = S_RELEASED;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + cnt_t'(1);
                    end
                end
                default: begin
                    w_state_nxt[i] = S_RELEASED;
                    w_cnt_nxt[i]   = '0;
                end
            endcase

            w_held_nxt[i] = (w_state_nxt[i] == S_PRESSED) ||
                            (w_state_nxt[i] == S_RELEASE_PENDING);
        end
    end

    assign bus.button_pressed = r_pressed;
    assign bus.button_held    = r_held;

endmodule
